// File: rtl/fp_minmax_reduce_pkg.sv
// Shared types, constants and class-detection helper for the FP min/max reducer.
package fp_minmax_reduce_pkg;

  localparam int unsigned ELEM_W = 64;
  localparam int unsigned FLAG_W = 5;
  localparam int unsigned NV_BIT = 4;

  localparam logic [ELEM_W-1:0] CANON_NAN_D = 64'h7ff8_0000_0000_0000;
  localparam logic [ELEM_W-1:0] CANON_NAN_S = 64'h0000_0000_7fc0_0000;

  localparam logic [2:0] RM_MIN = 3'd0;
  localparam logic [2:0] RM_MAX = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // vld=0 marks an empty operand, which behaves as the identity of min/max
  typedef struct packed {
    logic              vld;
    logic [ELEM_W-1:0] val;
  } elem_t;

  // Returns {is_nan, is_snan}; single format looks at bits [31:0] only
  function automatic logic [1:0] fp_class(input logic [ELEM_W-1:0] v, input logic dbl);
    logic nan;
    logic quiet;
    if (dbl) begin
      nan   = (&v[62:52]) & (|v[51:0]);
      quiet = v[51];
    end else begin
      nan   = (&v[30:23]) & (|v[22:0]);
      quiet = v[22];
    end
    return {nan, nan & ~quiet};
  endfunction

endpackage

// File: rtl/fp_minmax_cmp.sv
// Two-operand IEEE min/max select with NaN handling and invalid detection.
module fp_minmax_cmp
  import fp_minmax_reduce_pkg::*;
(
  input  logic  dbl,
  input  logic  is_max,
  input  elem_t a,
  input  elem_t b,
  output elem_t y_c,
  output logic  nv_c
);

  logic [1:0]        a_cls;
  logic [1:0]        b_cls;
  logic              a_num;
  logic              b_num;
  logic [ELEM_W-1:0] a_ord;
  logic [ELEM_W-1:0] b_ord;
  logic              a_lt_b;

  // Classify, order and select; NaN or empty operands fall away to the other side
  always_comb begin
    a_cls  = fp_class(a.val, dbl);
    b_cls  = fp_class(b.val, dbl);
    a_num  = a.vld & ~a_cls[1];
    b_num  = b.vld & ~b_cls[1];
    nv_c   = (a.vld & a_cls[0]) | (b.vld & b_cls[0]);

    // Align single values so the sign sits at bit 63 for a common compare
    a_ord  = dbl ? a.val : {a.val[31:0], 32'h0};
    b_ord  = dbl ? b.val : {b.val[31:0], 32'h0};

    if (a_ord[63] != b_ord[63]) begin
      a_lt_b = a_ord[63];
    end else if (!a_ord[63]) begin
      a_lt_b = a_ord[62:0] < b_ord[62:0];
    end else begin
      a_lt_b = a_ord[62:0] > b_ord[62:0];
    end

    y_c.vld = 1'b0;
    y_c.val = dbl ? CANON_NAN_D : CANON_NAN_S;
    if (a_num && b_num) begin
      y_c = (is_max ? a_lt_b : ~a_lt_b) ? b : a;
    end else if (a_num) begin
      y_c = a;
    end else if (b_num) begin
      y_c = b;
    end
  end

endmodule

// File: rtl/fp_minmax_reduce.sv
// Frame-based floating-point min/max reduction over LANES elements per beat.
module fp_minmax_reduce
  import fp_minmax_reduce_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned FLEN  = 64
) (
  input  logic                  fp_minmax_reduce_i_clk,
  input  logic                  fp_minmax_reduce_i_rst_n,
  input  logic                  fp_minmax_reduce_i_valid,
  output logic                  fp_minmax_reduce_o_ready,
  input  logic [LANES*FLEN-1:0] fp_minmax_reduce_i_data,
  input  logic [LANES-1:0]      fp_minmax_reduce_i_mask,
  input  logic                  fp_minmax_reduce_i_last,
  input  logic [1:0]            fp_minmax_reduce_i_fmt,
  input  logic [2:0]            fp_minmax_reduce_i_rm,
  output logic                  fp_minmax_reduce_o_valid,
  input  logic                  fp_minmax_reduce_i_ready,
  output logic [FLEN-1:0]       fp_minmax_reduce_o_result,
  output logic [FLAG_W-1:0]     fp_minmax_reduce_o_flags
);

  state_t           state_q;
  state_t           state_d;
  elem_t            acc_q;
  logic             nv_q;
  logic             dbl_q;
  logic [2:0]       rm_q;

  logic             beat_c;
  logic             take_c;
  logic             dbl_c;
  logic [2:0]       rm_c;
  logic             is_max_c;
  elem_t            acc_in_c;
  logic             nv_in_c;
  elem_t            tree_y_c;
  logic [LANES-1:0] lane_nv_c;
  elem_t            acc_y_c;
  logic             acc_nv_c;
  logic             nv_sum_c;

  assign beat_c = fp_minmax_reduce_i_valid & fp_minmax_reduce_o_ready;
  assign take_c = fp_minmax_reduce_o_valid & fp_minmax_reduce_i_ready;

  // First beat of a frame uses live fmt/rm and an empty accumulator; later beats use captured ones
  always_comb begin
    dbl_c    = dbl_q;
    rm_c     = rm_q;
    acc_in_c = acc_q;
    nv_in_c  = nv_q;
    if (state_q == ST_IDLE) begin
      dbl_c    = (fp_minmax_reduce_i_fmt != 2'd0);
      rm_c     = fp_minmax_reduce_i_rm;
      acc_in_c = '0;
      nv_in_c  = 1'b0;
    end
    is_max_c = (rm_c == RM_MAX);
  end

  // Lane chain seeded with an empty operand so every lane gets class detection
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    elem_t lane_c;
    elem_t a_c;
    elem_t y_c;
    logic  nv_c;

    assign lane_c = {fp_minmax_reduce_i_mask[k],
                     dbl_c ? fp_minmax_reduce_i_data[k*FLEN +: FLEN]
                           : {32'h0, fp_minmax_reduce_i_data[k*FLEN +: 32]}};

    if (k == 0) begin : g_seed
      assign a_c = '0;
    end else begin : g_link
      assign a_c = g_lane[k-1].y_c;
    end

    fp_minmax_cmp u_cmp (
      .dbl    (dbl_c),
      .is_max (is_max_c),
      .a      (a_c),
      .b      (lane_c),
      .y_c    (y_c),
      .nv_c   (nv_c)
    );

    assign lane_nv_c[k] = nv_c;

    if (k == LANES - 1) begin : g_tail
      assign tree_y_c = y_c;
    end
  end

  fp_minmax_cmp u_acc_cmp (
    .dbl    (dbl_c),
    .is_max (is_max_c),
    .a      (acc_in_c),
    .b      (tree_y_c),
    .y_c    (acc_y_c),
    .nv_c   (acc_nv_c)
  );

  assign nv_sum_c = nv_in_c | (|lane_nv_c) | acc_nv_c;

  // FSM state register
  always_ff @(posedge fp_minmax_reduce_i_clk or negedge fp_minmax_reduce_i_rst_n) begin
    if (!fp_minmax_reduce_i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: frame open on first beat, result held until taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (beat_c) state_d = fp_minmax_reduce_i_last ? ST_DONE : ST_ACC;
      ST_ACC:  if (beat_c && fp_minmax_reduce_i_last) state_d = ST_DONE;
      ST_DONE: if (take_c) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Accumulator, captured mode, and registered handshake/result outputs
  always_ff @(posedge fp_minmax_reduce_i_clk or negedge fp_minmax_reduce_i_rst_n) begin
    if (!fp_minmax_reduce_i_rst_n) begin
      acc_q                     <= '0;
      nv_q                      <= 1'b0;
      dbl_q                     <= 1'b0;
      rm_q                      <= 3'd0;
      fp_minmax_reduce_o_ready  <= 1'b1;
      fp_minmax_reduce_o_valid  <= 1'b0;
      fp_minmax_reduce_o_result <= '0;
      fp_minmax_reduce_o_flags  <= '0;
    end else begin
      fp_minmax_reduce_o_ready <= (state_d != ST_DONE);
      fp_minmax_reduce_o_valid <= (state_d == ST_DONE);
      if (beat_c) begin
        acc_q <= acc_y_c;
        nv_q  <= nv_sum_c;
        dbl_q <= dbl_c;
        rm_q  <= rm_c;
        if (fp_minmax_reduce_i_last) begin
          fp_minmax_reduce_o_result <= '0;
          fp_minmax_reduce_o_flags  <= '0;
          if ((rm_c == RM_MIN) || (rm_c == RM_MAX)) begin
            // An empty final value already carries the canonical NaN for the format
            fp_minmax_reduce_o_result         <= acc_y_c.val;
            fp_minmax_reduce_o_flags[NV_BIT]  <= nv_sum_c;
          end
        end
      end else if (take_c) begin
        acc_q <= '0;
        nv_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_minmax_reduce.sv
// Randomized and directed bench for fp_minmax_reduce with a reference model.
module tb_fp_minmax_reduce;

  localparam int unsigned LANES = 4;
  localparam int unsigned DW    = LANES * 64;

  logic            clk;
  logic            rst_n;
  logic            i_valid;
  logic            o_ready;
  logic [DW-1:0]   i_data;
  logic [LANES-1:0] i_mask;
  logic            i_last;
  logic [1:0]      i_fmt;
  logic [2:0]      i_rm;
  logic            o_valid;
  logic            i_ready;
  logic [63:0]     o_result;
  logic [4:0]      o_flags;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state for the open frame
  bit          m_open;
  bit          m_dbl;
  logic [2:0]  m_rm;
  bit          m_have;
  logic [63:0] m_best;
  bit          m_nv;

  fp_minmax_reduce #(.LANES(LANES), .FLEN(64)) dut (
    .fp_minmax_reduce_i_clk    (clk),
    .fp_minmax_reduce_i_rst_n  (rst_n),
    .fp_minmax_reduce_i_valid  (i_valid),
    .fp_minmax_reduce_o_ready  (o_ready),
    .fp_minmax_reduce_i_data   (i_data),
    .fp_minmax_reduce_i_mask   (i_mask),
    .fp_minmax_reduce_i_last   (i_last),
    .fp_minmax_reduce_i_fmt    (i_fmt),
    .fp_minmax_reduce_i_rm     (i_rm),
    .fp_minmax_reduce_o_valid  (o_valid),
    .fp_minmax_reduce_i_ready  (i_ready),
    .fp_minmax_reduce_o_result (o_result),
    .fp_minmax_reduce_o_flags  (o_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_nan(input logic [63:0] v, input bit dbl);
    if (dbl) return (v[62:52] == 11'h7ff) && (v[51:0] != 52'h0);
    return (v[30:23] == 8'hff) && (v[22:0] != 23'h0);
  endfunction

  function automatic bit is_snan(input logic [63:0] v, input bit dbl);
    return is_nan(v, dbl) && (dbl ? !v[51] : !v[22]);
  endfunction

  // Total-order key: larger key means larger value, with -0 below +0
  function automatic logic [64:0] okey(input logic [63:0] v, input bit dbl);
    logic [63:0] s;
    s = dbl ? v : {v[31:0], 32'h0};
    return s[63] ? {1'b0, ~s} : {1'b1, s};
  endfunction

  task automatic model_clear();
    m_open = 0; m_have = 0; m_nv = 0; m_best = '0;
  endtask

  task automatic model_beat(input logic [DW-1:0] d, input logic [LANES-1:0] m,
                            input logic [1:0] f, input logic [2:0] r);
    logic [63:0] v;
    if (!m_open) begin
      m_open = 1; m_dbl = (f != 2'd0); m_rm = r;
    end
    for (int k = 0; k < LANES; k++) begin
      if (m[k]) begin
        v = d[k*64 +: 64];
        if (!m_dbl) v = {32'h0, v[31:0]};
        if (is_snan(v, m_dbl)) m_nv = 1;
        if (!is_nan(v, m_dbl)) begin
          if (!m_have) begin
            m_best = v; m_have = 1;
          end else if (m_rm == 3'd1 ? (okey(v, m_dbl) > okey(m_best, m_dbl))
                                     : (okey(v, m_dbl) < okey(m_best, m_dbl))) begin
            m_best = v;
          end
        end
      end
    end
  endtask

  task automatic model_final(output logic [63:0] r, output logic [4:0] fl);
    if (m_rm > 3'd1) begin
      r = '0; fl = '0;
    end else begin
      r  = m_have ? m_best : (m_dbl ? 64'h7ff8000000000000 : 64'h000000007fc00000);
      fl = m_nv ? 5'h10 : 5'h00;
    end
    model_clear();
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [LANES-1:0] m, input logic l,
                           input logic [1:0] f, input logic [2:0] r);
    @(negedge clk);
    check("ready_beat", 64'(o_ready), 64'd1);
    i_data = d; i_mask = m; i_last = l; i_fmt = f; i_rm = r; i_valid = 1'b1;
    model_beat(d, m, f, r);
    @(posedge clk);
    #1 i_valid = 1'b0;
  endtask

  // Result must be up one cycle after the last beat; optionally held before taking
  task automatic get_result(input string tag, input logic [63:0] er, input logic [4:0] ef,
                            input int hold);
    @(negedge clk);
    check({tag, "_valid"}, 64'(o_valid), 64'd1);
    check({tag, "_result"}, o_result, er);
    check({tag, "_flags"}, 64'(o_flags), 64'(ef));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold"}, o_result, er);
    end
    i_ready = 1'b1;
    @(posedge clk);
    #1 i_ready = 1'b0;
    @(negedge clk);
    check({tag, "_idle_valid"}, 64'(o_valid), 64'd0);
    check({tag, "_idle_ready"}, 64'(o_ready), 64'd1);
  endtask

  function automatic logic [63:0] rnd_elem(input bit dbl);
    logic [63:0] v;
    int unsigned sel;
    sel = $urandom_range(0, 11);
    if (dbl) begin
      case (sel)
        0: v = 64'h0000000000000000;
        1: v = 64'h8000000000000000;
        2: v = 64'h3ff0000000000000;
        3: v = 64'hbff0000000000000;
        4: v = 64'h7ff0000000000000;
        5: v = 64'hfff0000000000000;
        6: v = 64'h7ff8000000000000;
        7: v = 64'h7ff4000000000000;
        8: v = 64'hfff0000000000001;
        9: v = 64'h4000000000000000;
        default: v = {$urandom, $urandom};
      endcase
    end else begin
      v[63:32] = $urandom;
      case (sel)
        0: v[31:0] = 32'h00000000;
        1: v[31:0] = 32'h80000000;
        2: v[31:0] = 32'h3f800000;
        3: v[31:0] = 32'hbf800000;
        4: v[31:0] = 32'h7f800000;
        5: v[31:0] = 32'hff800000;
        6: v[31:0] = 32'h7fc00000;
        7: v[31:0] = 32'h7fa00000;
        8: v[31:0] = 32'hff800001;
        9: v[31:0] = 32'h40000000;
        default: v[31:0] = $urandom;
      endcase
    end
    return v;
  endfunction

  initial begin
    logic [DW-1:0] d;
    logic [63:0]   er;
    logic [4:0]    ef;
    logic [63:0]   held;
    int            nb;
    logic [1:0]    f0;
    logic [2:0]    r0;
    logic [LANES-1:0] msk;

    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_data = '0; i_mask = '0;
    i_last = 1'b0; i_fmt = 2'd0; i_rm = 3'd0;
    model_clear();
    #12;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_result", o_result, 64'd0);
    check("rst_flags", 64'(o_flags), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Double max, one beat
    d = {64'h3fe0000000000000, 64'h400c000000000000, 64'hc000000000000000, 64'h3ff0000000000000};
    send_beat(d, 4'hf, 1'b1, 2'd1, 3'd1);
    model_clear();
    get_result("dmax", 64'h400c000000000000, 5'h00, 0);

    // Single min over two beats; fmt/rm on the second beat must be ignored
    d = {64'h000000003f800000, 64'h000000007f800000, 64'h0000000080000000, 64'h0000000000000000};
    send_beat(d, 4'hf, 1'b0, 2'd0, 3'd0);
    d = {64'hfff4000000000000, 64'hfff4000000000000, 64'hfff4000000000000, 64'h12345678bf800000};
    send_beat(d, 4'h1, 1'b1, 2'd1, 3'd1);
    model_clear();
    get_result("smin", 64'h00000000bf800000, 5'h00, 0);

    // Double min with sNaN in lane 2, then the same frame with lane 2 masked
    d = {64'h4000000000000000, 64'h7ff4000000000000, 64'h4000000000000000, 64'h4000000000000000};
    send_beat(d, 4'hf, 1'b1, 2'd3, 3'd0);
    model_clear();
    get_result("snan", 64'h4000000000000000, 5'h10, 0);
    send_beat(d, 4'hb, 1'b1, 2'd3, 3'd0);
    model_clear();
    get_result("snan_mask", 64'h4000000000000000, 5'h00, 0);

    // Empty frame in single format
    send_beat({DW{1'b1}}, 4'h0, 1'b1, 2'd0, 3'd0);
    model_clear();
    get_result("empty", 64'h000000007fc00000, 5'h00, 0);

    // Unsupported rm consumes the frame and returns zero
    send_beat(d, 4'hf, 1'b1, 2'd1, 3'd5);
    model_clear();
    get_result("rm_bad", 64'h0, 5'h00, 0);

    // Held result while beats are offered
    d = {64'h0, 64'h0, 64'h0, 64'h4022000000000000};
    send_beat(d, 4'h1, 1'b1, 2'd1, 3'd1);
    model_clear();
    @(negedge clk);
    held = o_result;
    check("hold_first", held, 64'h4022000000000000);
    for (int c = 0; c < 5; c++) begin
      i_valid = 1'b1; i_data = {DW{1'b0}}; i_mask = 4'hf; i_last = 1'b1; i_fmt = 2'd1; i_rm = 3'd0;
      @(negedge clk);
      check("hold_ready", 64'(o_ready), 64'd0);
      check("hold_result", o_result, 64'h4022000000000000);
      check("hold_valid", 64'(o_valid), 64'd1);
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk);
    #1 i_ready = 1'b0;
    @(negedge clk);
    check("hold_idle", 64'(o_valid), 64'd0);
    d = {64'h0, 64'h0, 64'h0, 64'h3ff0000000000000};
    send_beat(d, 4'h1, 1'b1, 2'd1, 3'd1);
    model_clear();
    get_result("post_hold", 64'h3ff0000000000000, 5'h00, 0);

    // Reset mid-frame, then a fresh frame
    d = {64'h0, 64'h0, 64'h7ff4000000000000, 64'h4022000000000000};
    send_beat(d, 4'h7, 1'b0, 2'd1, 3'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_acc_valid", 64'(o_valid), 64'd0);
    check("rst_acc_ready", 64'(o_ready), 64'd1);
    model_clear();
    @(negedge clk) rst_n = 1'b1;
    d = {64'h0, 64'h0, 64'h0, 64'h4014000000000000};
    send_beat(d, 4'h1, 1'b1, 2'd1, 3'd1);
    model_clear();
    get_result("rst_fresh", 64'h4014000000000000, 5'h00, 0);

    // Reset while a result is pending
    send_beat(d, 4'h1, 1'b1, 2'd1, 3'd1);
    model_clear();
    #2 rst_n = 1'b0;
    #1;
    check("rst_done_valid", 64'(o_valid), 64'd0);
    check("rst_done_result", o_result, 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Random frames against the reference model
    for (int fr = 0; fr < 80; fr++) begin
      nb = $urandom_range(1, 4);
      f0 = 2'($urandom_range(0, 3));
      r0 = ($urandom_range(0, 9) > 7) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
      for (int b = 0; b < nb; b++) begin
        for (int k = 0; k < LANES; k++) d[k*64 +: 64] = rnd_elem(f0 != 2'd0);
        msk = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
        if (b == 0) send_beat(d, msk, (b == nb - 1), f0, r0);
        else        send_beat(d, msk, (b == nb - 1), 2'($urandom), 3'($urandom));
      end
      model_final(er, ef);
      get_result("rnd", er, ef, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_minmax_reduce.md
FP_MINMAX_REDUCE -- requirements
Module: fp_minmax_reduce

Interface
REQ-001 Parameter LANES, default 4, meaning elements per input beat (1..16).
REQ-002 Parameter FLEN, default 64, meaning element container width; fixed at 64 in this generation.
REQ-003 fp_minmax_reduce_i_clk  in  1  single clock; all state updates on rising edge.
REQ-004 fp_minmax_reduce_i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 fp_minmax_reduce_i_valid / _o_ready  in/out  1/1  input beat handshake.
REQ-006 fp_minmax_reduce_i_data  in  LANES*64  packed elements, lane k at [64k+63:64k].
REQ-007 fp_minmax_reduce_i_mask  in  LANES  lane enable; 0 = lane excluded.
REQ-008 fp_minmax_reduce_i_last  in  1  final beat of frame.
REQ-009 fp_minmax_reduce_i_fmt  in  2  0 = single (bits [31:0]), any other value = double.
REQ-010 fp_minmax_reduce_i_rm  in  3  0 = min, 1 = max, 2..7 = unsupported.
REQ-011 fp_minmax_reduce_o_valid / _i_ready  out/in  1/1  result handshake.
REQ-012 fp_minmax_reduce_o_result  out  64  reduced value; single results zero-extended.
REQ-013 fp_minmax_reduce_o_flags  out  5  exception flags; only bit 4 (NV) is ever set.

Function
REQ-014 Input beat transfers when i_valid and o_ready are both 1; result transfers when o_valid and i_ready are both 1.
REQ-015 FSM states: IDLE (no frame open), ACC (frame open), DONE (result held).
REQ-016 IDLE: o_ready=1; beat accepted with last=0 -> ACC; beat accepted with last=1 -> DONE.
REQ-017 ACC: o_ready=1; beat accepted with last=1 -> DONE; otherwise stay.
REQ-018 DONE: o_ready=0, o_valid=1; result accepted -> IDLE; result and flags are held stable until accepted.
REQ-019 fmt and rm are captured on the first beat of a frame; values on later beats are ignored.
REQ-020 Each accepted beat combines its active lanes and the accumulator in one cycle (lane tree plus accumulator); latency is one cycle from acceptance of the last beat to o_valid=1.
REQ-021 Pairwise rule: sNaN operand sets NV; a NaN operand (quiet or signalling) yields the other operand; two NaNs yield canonical NaN.
REQ-022 Canonical NaN is 64'h7ff8000000000000 for double and 64'h000000007fc00000 for single.
REQ-023 Non-NaN ordering: differing signs -> the negative operand is less; equal signs -> magnitude compare, reversed when both are negative; therefore -0 < +0.
REQ-024 The accumulator starts each frame empty; an empty accumulator acts as an identity operand and never raises NV.
REQ-025 A frame with zero active lanes, or with only NaN active lanes, returns canonical NaN; NV is set iff any active lane is sNaN.
REQ-026 NV is the sticky OR across all active lanes of the frame.
REQ-027 rm of 2..7 consumes the frame normally and returns result 0 with flags 0.
REQ-028 Masked-off lanes never affect the result or the flags, even when they hold sNaN.
REQ-029 Class detection (sNaN, qNaN) is done internally from exponent and mantissa per fmt; single mode ignores data bits [63:32].

Reset
REQ-030 rst_n=0 forces IDLE, o_valid=0, o_result=0, o_flags=0, the accumulator to empty, and clears the captured fmt/rm; it takes effect without a clock edge.
REQ-031 Reset during ACC or DONE discards the open frame or the pending result; the first beat after reset starts a new frame.

Structure
REQ-032 A shared package holds the canonical NaN constants, the rm encodings (MIN=0, MAX=1), the FSM state type, and the NV flag bit index.
REQ-033 The combinational two-operand compare-select with its class detection is sub-module fp_minmax_cmp; it is instantiated as a LANES-deep tree plus one accumulator stage.

Verification
REQ-034 Double max, LANES=4, one beat {1.0, -2.0, 3.5, 0.5}, mask=4'hF, last=1 -> next cycle result 64'h400C000000000000, flags 0.
REQ-035 Single min over two beats {+0, -0, 7f800000, 3f800000} then {bf800000, ...}, mask 4'hF then 4'h1 -> result 00000000bf800000, flags 0.
REQ-036 Double min with sNaN 64'h7ff4000000000000 in lane 2 and 2.0 elsewhere -> result 64'h4000000000000000, flags 5'h10; the same frame with lane 2 masked -> flags 0.
REQ-037 Frame with all masks 0, fmt=0 -> result 64'h000000007fc00000, flags 0.
REQ-038 Result held with i_ready=0 for 5 cycles -> o_ready=0 and result stable; i_valid beats ignored; i_ready=1 -> IDLE next cycle.
REQ-039 rst_n pulled low mid-ACC between clock edges -> o_valid=0 immediately; a fresh one-beat frame {5.0} in max mode -> 64'h4014000000000000.
